// File: rtl/skullfet_tester_pkg.sv
// Shared types and ideal truth tables for the SkullFET cell self-test sequencer.
package skullfet_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;

    // Ideal inverter response: inv_a is driven from idx[0].
    function automatic logic exp_inv(input logic [1:0] idx);
        case (idx)
            2'd0:    return 1'b1;
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            2'd3:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Ideal NAND response: nand_a = idx[1], nand_b = idx[0].
    function automatic logic exp_nand(input logic [1:0] idx);
        case (idx)
            2'd3:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/skullfet_sync2.sv
// Two-flop synchronizer for an asynchronous SkullFET cell output.
module skullfet_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Capture the asynchronous input and let metastability resolve for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/skullfet_cell_tester.sv
// Self-test sequencer: drives all four vectors into the SkullFET inverter/NAND
// cells, samples their synchronized outputs after a settle time and logs mismatches.
module skullfet_cell_tester
    import skullfet_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             loop_en,
    output logic             inv_a,
    output logic             nand_a,
    output logic             nand_b,
    input  logic             inv_y,
    input  logic             nand_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       fail_map,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t           state_r;
    logic [1:0]       idx_r;
    logic [7:0]       cnt_r;
    logic             inv_sync_s;
    logic             nand_sync_s;
    logic [1:0]       idx_inc_s;
    logic             inv_err_s;
    logic             nand_err_s;
    logic [7:0]       fail_next_s;
    logic [ERR_W:0]   err_sum_s;
    logic [ERR_W-1:0] err_next_s;

    skullfet_sync2 u_sync_inv (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (inv_y),
        .q   (inv_sync_s)
    );

    skullfet_sync2 u_sync_nand (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (nand_y),
        .q   (nand_sync_s)
    );

    // Compare the synchronized cell outputs for the current vector and build the result updates.
    always_comb begin
        idx_inc_s   = idx_r + 2'd1;
        inv_err_s   = (inv_sync_s != exp_inv(idx_r));
        nand_err_s  = (nand_sync_s != exp_nand(idx_r));
        fail_next_s = fail_map;
        fail_next_s[{1'b0, idx_r}] = fail_map[{1'b0, idx_r}] | inv_err_s;
        fail_next_s[{1'b1, idx_r}] = fail_map[{1'b1, idx_r}] | nand_err_s;
        // One extra bit catches a +1/+2 overflow so the count can stick at all-ones.
        err_sum_s = {1'b0, err_count} + {{ERR_W{1'b0}}, inv_err_s} + {{ERR_W{1'b0}}, nand_err_s};
        if (err_sum_s[ERR_W]) begin
            err_next_s = {ERR_W{1'b1}};
        end else begin
            err_next_s = err_sum_s[ERR_W-1:0];
        end
    end

    // Sequencer FSM with registered stimulus, status and result outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r   <= ST_IDLE;
            idx_r     <= 2'd0;
            cnt_r     <= 8'd0;
            inv_a     <= 1'b0;
            nand_a    <= 1'b0;
            nand_b    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_map  <= 8'h00;
            err_count <= {ERR_W{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    inv_a  <= 1'b0;
                    nand_a <= 1'b0;
                    nand_b <= 1'b0;
                    if (start) begin
                        state_r   <= ST_DRIVE;
                        idx_r     <= 2'd0;
                        cnt_r     <= SETTLE_LOAD;
                        fail_map  <= 8'h00;
                        err_count <= {ERR_W{1'b0}};
                        busy      <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_r == 8'd0) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    fail_map  <= fail_next_s;
                    err_count <= err_next_s;
                    if (idx_r == 2'd3) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                        pass    <= (fail_next_s == 8'h00);
                        inv_a   <= 1'b0;
                        nand_a  <= 1'b0;
                        nand_b  <= 1'b0;
                    end else begin
                        state_r <= ST_DRIVE;
                        idx_r   <= idx_inc_s;
                        cnt_r   <= SETTLE_LOAD;
                        inv_a   <= idx_inc_s[0];
                        nand_a  <= idx_inc_s[1];
                        nand_b  <= idx_inc_s[0];
                    end
                end
                ST_DONE: begin
                    inv_a  <= 1'b0;
                    nand_a <= 1'b0;
                    nand_b <= 1'b0;
                    if (loop_en) begin
                        state_r  <= ST_DRIVE;
                        idx_r    <= 2'd0;
                        cnt_r    <= SETTLE_LOAD;
                        fail_map <= 8'h00;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skullfet_cell_tester.sv
// Directed self-checking bench: ideal and faulty cell models around two tester instances (S=4, S=3).
module tb_skullfet_cell_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, loop_a, inv_a_a, nand_a_a, nand_b_a, inv_y_a, nand_y_a;
    logic       busy_a, done_a, pass_a;
    logic [7:0] fm_a, ec_a;
    logic       start_b, loop_b, inv_a_b, nand_a_b, nand_b_b, inv_y_b, nand_y_b;
    logic       busy_b, done_b, pass_b;
    logic [7:0] fm_b, ec_b;
    logic       inv_stuck1, nand_stuck0;

    int checks   = 0;
    int failures = 0;

    assign inv_y_a  = inv_stuck1  ? 1'b1 : ~inv_a_a;
    assign nand_y_a = nand_stuck0 ? 1'b0 : ~(nand_a_a & nand_b_a);
    assign inv_y_b  = ~inv_a_b;
    assign nand_y_b = ~(nand_a_b & nand_b_b);

    skullfet_cell_tester #(.SETTLE_CYCLES(4), .ERR_W(8)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_a), .loop_en(loop_a),
        .inv_a(inv_a_a), .nand_a(nand_a_a), .nand_b(nand_b_a),
        .inv_y(inv_y_a), .nand_y(nand_y_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .fail_map(fm_a), .err_count(ec_a)
    );

    skullfet_cell_tester #(.SETTLE_CYCLES(3), .ERR_W(8)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_b), .loop_en(loop_b),
        .inv_a(inv_a_b), .nand_a(nand_a_b), .nand_b(nand_b_b),
        .inv_y(inv_y_b), .nand_y(nand_y_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .fail_map(fm_b), .err_count(ec_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_pulse_a();
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int limit, output int cyc, output logic seen);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_a) seen = 1'b1;
        end
    endtask

    task automatic check_all_zero_a(input string tag);
        check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
        check({tag, "_done"}, {31'd0, done_a}, 32'd0);
        check({tag, "_pass"}, {31'd0, pass_a}, 32'd0);
        check({tag, "_fm"},   {24'd0, fm_a}, 32'd0);
        check({tag, "_err"},  {24'd0, ec_a}, 32'd0);
        check({tag, "_stim"}, {29'd0, inv_a_a, nand_a_a, nand_b_a}, 32'd0);
    endtask

    task automatic run_a(input string tag, input logic [7:0] exp_fm,
                         input logic [7:0] exp_err, input logic exp_pass);
        int   cyc;
        logic seen;
        start_pulse_a();
        check({tag, "_busy"}, {31'd0, busy_a}, 32'd1);
        wait_done_a(100, cyc, seen);
        check({tag, "_seen"},  {31'd0, seen}, 32'd1);
        check({tag, "_cycle"}, cyc + 1, 32'd21);
        check({tag, "_fm"},    {24'd0, fm_a}, {24'd0, exp_fm});
        check({tag, "_err"},   {24'd0, ec_a}, {24'd0, exp_err});
        check({tag, "_pass"},  {31'd0, pass_a}, {31'd0, exp_pass});
        @(posedge clk);
        #1;
        check({tag, "_idle"},  {30'd0, busy_a, done_a}, 32'd0);
    endtask

    initial begin
        int   cyc;
        int   exp_err;
        logic seen;
        logic any_done;

        rst = 1'b1;
        start_a = 1'b0; loop_a = 1'b0; start_b = 1'b0; loop_b = 1'b0;
        inv_stuck1 = 1'b0; nand_stuck0 = 1'b0;
        #1;
        check_all_zero_a("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_a("healthy", 8'h00, 8'd0, 1'b1);

        inv_stuck1 = 1'b1;
        run_a("inv_stuck1", 8'h0A, 8'd2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_fm_idle", {24'd0, fm_a}, 32'h0A);
        inv_stuck1 = 1'b0;

        nand_stuck0 = 1'b1;
        run_a("nand_stuck0", 8'h70, 8'd3, 1'b0);
        nand_stuck0 = 1'b0;

        // Back-to-back looping runs with a stuck inverter until err_count saturates.
        inv_stuck1 = 1'b1;
        loop_a     = 1'b1;
        start_pulse_a();
        for (int r = 1; r <= 130; r++) begin
            wait_done_a(100, cyc, seen);
            check("loop_seen", {31'd0, seen}, 32'd1);
            check("loop_cycle", cyc, (r == 1) ? 32'd20 : 32'd21);
            check("loop_fm", {24'd0, fm_a}, 32'h0A);
            exp_err = (2 * r > 255) ? 255 : 2 * r;
            check("loop_err", {24'd0, ec_a}, exp_err);
        end
        repeat (5) @(posedge clk);
        #1;
        loop_a = 1'b0;
        check("loop_drop_busy", {31'd0, busy_a}, 32'd1);
        wait_done_a(100, cyc, seen);
        check("loop_last_seen", {31'd0, seen}, 32'd1);
        check("loop_last_cycle", cyc, 32'd16);
        check("loop_last_fm", {24'd0, fm_a}, 32'h0A);
        check("loop_last_err", {24'd0, ec_a}, 32'd255);
        @(posedge clk);
        #1;
        check("loop_end_busy", {31'd0, busy_a}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("loop_end_stays_idle", {31'd0, busy_a}, 32'd0);
        inv_stuck1 = 1'b0;

        // Asynchronous reset in the middle of vector 1 (inv_a is 1 there).
        start_pulse_a();
        repeat (7) @(posedge clk);
        #1;
        check("pre_rst_inv_a", {31'd0, inv_a_a}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero_a("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        any_done = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            any_done = any_done | done_a;
        end
        check("no_done_after_rst", {31'd0, any_done}, 32'd0);
        check("idle_after_rst", {31'd0, busy_a}, 32'd0);
        run_a("after_rst", 8'h00, 8'd0, 1'b1);

        // S=3 instance: start re-pulsed while busy must not disturb the run.
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        check("s3_busy", {31'd0, busy_b}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        cyc  = 6;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_b) seen = 1'b1;
        end
        check("s3_seen", {31'd0, seen}, 32'd1);
        check("s3_cycle", cyc + 1, 32'd17);
        check("s3_pass", {31'd0, pass_b}, 32'd1);
        check("s3_fm", {24'd0, fm_b}, 32'd0);
        check("s3_err", {24'd0, ec_b}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("s3_idle", {30'd0, busy_b, done_b}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/skullfet_cell_tester.md
# skullfet_cell_tester

On-die self-test sequencer for the SkullFET inverter and NAND test cells. On a start request it drives all four input vectors onto the cells' inputs. After a programmable settle time per vector, it samples the cell outputs through synchronizers and checks them against the ideal truth tables. Results are reported as a per-vector fail map, a saturating error count and a pass flag. It sits in the user project wrapper between the IO/logic-analyzer pins and the analog-ish SkullFET cells.

## Interface
- SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range 3..255. The 2-flop synchronizer needs at least 3.
- ERR_W, 8, width of err_count.

- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- start  in  1  level, sampled only in IDLE; starts a run
- loop_en  in  1  when high, a new run begins right after DONE
- inv_a  out  1  drives inverter input A
- nand_a  out  1  drives NAND input A
- nand_b  out  1  drives NAND input B
- inv_y  in  1  inverter output, asynchronous
- nand_y  in  1  NAND output, asynchronous
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at the end of each run
- pass  out  1  result of the last completed run: 1 when fail_map was all zero
- fail_map  out  8  bits [3:0] = inverter fail per vector index; bits [7:4] = NAND fail per vector index
- err_count  out  ERR_W  accumulated mismatches; saturates at all-ones

## Operation
- **Vector index** idx is 0..3.
  - nand_a = idx[1], nand_b = idx[0], inv_a = idx[0].
  - Expected outputs: inv_y = ~idx[0]; nand_y = ~(idx[1] & idx[0]).
- **States:** IDLE, DRIVE, SAMPLE, DONE.
- **IDLE**
  - Stimulus outputs are 0.
  - On start = 1: idx←0, fail_map←0, err_count←0, go to DRIVE.
- **DRIVE**
  - Stimulus outputs registered from idx on the entry edge.
  - Settle counter loads SETTLE_CYCLES−1 on entry and decrements each cycle; at 0, go to SAMPLE.
- **SAMPLE** (one cycle)
  - Compare the synchronized outputs against the expected values.
  - Set fail_map[idx] on inverter mismatch and fail_map[4+idx] on NAND mismatch.
  - err_count += number of mismatches (0..2), saturating.
  - If idx = 3, go to DONE; otherwise idx++ and go to DRIVE.
- **DONE** (one cycle)
  - done = 1; pass ← (fail_map == 0), including any SAMPLE update from the preceding cycle.
  - If loop_en: idx←0, fail_map←0 (err_count keeps accumulating), go to DRIVE.
  - Otherwise go to IDLE.
- start is ignored outside IDLE. Deasserting loop_en mid-run lets the current run finish normally.
- fail_map and pass hold their values in IDLE until the next run starts.

## Timing
- **Reset values:** every output is 0 (inv_a, nand_a, nand_b, busy, done, pass, fail_map, err_count), state is IDLE, idx = 0, and both synchronizers are cleared.
- **Reset mid-run:** all state clears immediately (asynchronous); no done pulse is produced.
- **Example with S = SETTLE_CYCLES = 4:**
  - start sampled at edge 0.
  - DRIVE covers cycles 1–4, SAMPLE is cycle 5.
  - Each vector takes S+1 cycles, so SAMPLE for vector 3 is cycle 20 and DONE is cycle 21.
  - busy is high in cycles 1–21.
  - General run length: 4·(S+1)+1 cycles.
- **Synchronizer:** inv_y/nand_y pass through a 2-flop synchronizer. A change driven at DRIVE entry is visible to the compare logic no later than the third DRIVE cycle.
- **Looping:** back-to-back runs have no IDLE gap; DONE → DRIVE directly. If start stays high with loop_en = 0, runs are separated by a single IDLE cycle.
- **Saturation:** err_count sticks at 2^ERR_W−1, including when a +2 increment would overflow.

## Structure
- **Package skullfet_tester_pkg**
  - State enum (IDLE, DRIVE, SAMPLE, DONE).
  - NUM_VECTORS = 4.
  - Functions exp_inv(idx) and exp_nand(idx).
- **Sub-module skullfet_sync2:** 2-flop synchronizer with asynchronous active-high reset, instantiated once per cell output.
- **Top:** FSM, settle counter, idx register, result registers.

## Test plan
- **Healthy cells** (bench models ideal inverter/NAND), S = 4, start pulse → done at cycle 21, pass = 1, fail_map = 8'h00, err_count = 0.
- **Inverter output stuck at 1** → fail_map = 8'h0A, err_count = 2, pass = 0.
- **NAND output stuck at 0** → fail_map = 8'h70, err_count = 3, pass = 0.
- **loop_en = 1 with stuck inverter, 130 runs**
  - err_count saturates at 255.
  - fail_map reads 8'h0A at every done.
  - Drop loop_en mid-run → the run completes, then IDLE with busy = 0.
- **Reset at cycle 8 of a run** → all outputs 0 immediately, no done pulse. A start pulse afterwards gives a full normal run.
- **start pulsed during busy** → ignored, and the run timing is unchanged. With S = 3: DONE at cycle 17; check the compare still sees synchronized data (healthy cells → pass = 1).
